pio_bus_sequencer: RTL and testbench
====================================

Name: pio_bus_sequencer

Overview:
- Sequences a shared 4-bit-class data bus onto NUM_PORTS parallel-I/O peripheral ports.
- Each port has READ_IN / LOAD_OUT / LOAD_DIR strobes.
- Takes single-command requests (read pins, write output register, write direction register) from the host side and generates bus drive, one-hot strobes and capture timing.
- Returns read data with an ack pulse. Sits between the CPU/memory-mapped front end and the peripheral port array.

Parameters:
- N, 4, data bus width in bits.
- NUM_PORTS, 2, number of peripheral ports sharing data_bus.
- PORT_BITS, 1, width of port_sel; must satisfy 2**PORT_BITS >= NUM_PORTS.
- READ_LAT, 1, cycles READ_IN stays high after the STROBE cycle before data_bus is captured; range 1..15.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  command request; sampled only in IDLE.
- op  input  2  command: 00 READ, 01 WRITE_OUT, 10 WRITE_DIR, 11 READ_SHADOW (feature-dependent).
- port_sel  input  PORT_BITS  target port index.
- wr_data  input  N  write payload.
- busy  output  1  high in every state except IDLE.
- ack  output  1  one-cycle completion pulse.
- err  output  1  valid only with ack; high on a rejected command.
- rd_data  output  N  read result; holds until the next read completes.
- data_bus  inout  N  shared bus; driven only during write SETUP/STROBE/HOLD, else Z.
- read_in  output  NUM_PORTS  one-hot READ_IN strobes.
- load_out  output  NUM_PORTS  one-hot LOAD_OUT strobes.
- load_dir  output  NUM_PORTS  one-hot LOAD_DIR strobes.

Behaviour:
- Reset (async, immediate, also mid-operation):
  - state=IDLE; busy=ack=err=0; rd_data=0; all strobes 0; data_bus=Z; latched cmd registers 0.
- States: IDLE, SETUP, STROBE, WAIT, HOLD, DONE.
- IDLE:
  - On req=1, latch op, port_sel and wr_data.
  - If the command is invalid (op=11 without feature, or port_sel>=NUM_PORTS), go to DONE with err flagged. No strobe and no bus drive occur.
  - Otherwise go to SETUP.
- SETUP (1 cycle): writes drive data_bus=latched wr_data. Strobes low (setup time).
- STROBE (1 cycle):
  - Selected port's strobe=1; all others 0.
  - READ asserts read_in and leaves the bus at Z.
  - WRITE_OUT asserts load_out; WRITE_DIR asserts load_dir. Both keep driving the bus.
  - Next state: WAIT for READ, HOLD for writes.
- WAIT (READ only, READ_LAT cycles): read_in stays high. On the final WAIT cycle's edge rd_data<=data_bus. Then DONE.
- HOLD (writes, 1 cycle): strobes low, bus still driven (hold time). Then DONE.
- DONE (1 cycle): ack=1; err per command; bus Z; strobes low. Then IDLE.
- Latency from the req-sampling edge to ack high:
  - write: 4 cycles.
  - read: 3+READ_LAT cycles.
  - rejected: 1 cycle.
- At most one strobe bit is high in any cycle. load_out/load_dir are never high while data_bus is Z. read_in is never high while the block drives data_bus.
- req high while busy is ignored: no queueing, and the latched command is unchanged.
- req held high through DONE starts a new command on the IDLE edge. Back-to-back throughput is 1 command per latency+1 cycles.
- rd_data updates only on a successful READ (or READ_SHADOW); writes and errors leave it unchanged.

Optional Feature:
- Macro PIO_SHADOW_EN.
- Defined:
  - Per-port shadow registers out_sh and dir_sh (N bits each, reset 0) update on each completed WRITE_OUT/WRITE_DIR at the HOLD edge.
  - op=11 READ_SHADOW goes IDLE->DONE with no bus activity. It returns {dir_sh} in rd_data if wr_data[0]=1, else {out_sh}. Ack arrives 1 cycle after sampling, with err=0.
- Not defined: no shadow storage; op=11 is rejected with err=1.

Test Plan:
- Reset held 2 cycles, then released -> all strobes 0, data_bus Z, rd_data=0, busy=0; asserting reset mid-STROBE forces the same values immediately, without waiting for a clock edge.
- WRITE_OUT port 1, wr_data=4'hA -> data_bus=4'hA from SETUP through HOLD, load_out=2'b10 for exactly one cycle, ack on the 4th cycle after sampling, err=0.
- READ port 0 with the peripheral driving 4'b1010 while read_in[0]=1, READ_LAT=1 -> read_in=2'b01 for 2 cycles, rd_data=4'hA, ack at cycle 4, bus never driven by the block.
- port_sel=1 with NUM_PORTS=1 (or op=11 without the macro) -> ack+err one cycle after sampling, no strobe ever high.
- req pulsed during busy, then held high across DONE -> mid-op pulse ignored; second command starts the cycle after ack.
- With PIO_SHADOW_EN: WRITE_DIR port 0 4'h3, then READ_SHADOW wr_data=1 -> rd_data=4'h3, ack 1 cycle after sampling, no strobes.

Source files
------------

// File: rtl/pio_bus_sequencer.sv
// pio_bus_sequencer: one-command-at-a-time sequencer driving a shared PIO data bus and per-port strobes.
// Optional macro PIO_SHADOW_EN adds per-port out/dir shadow registers and the READ_SHADOW command.
module pio_bus_sequencer #(
    parameter int N         = 4,
    parameter int NUM_PORTS = 2,
    parameter int PORT_BITS = 1,
    parameter int READ_LAT  = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req,
    input  logic [1:0]           op,
    input  logic [PORT_BITS-1:0] port_sel,
    input  logic [N-1:0]         wr_data,
    output logic                 busy,
    output logic                 ack,
    output logic                 err,
    output logic [N-1:0]         rd_data,
    inout  wire  [N-1:0]         data_bus,
    output logic [NUM_PORTS-1:0] read_in,
    output logic [NUM_PORTS-1:0] load_out,
    output logic [NUM_PORTS-1:0] load_dir
);
    localparam logic [1:0] OP_READ = 2'b00, OP_OUT = 2'b01, OP_DIR = 2'b10, OP_SHADOW = 2'b11;

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAIT, HOLD, DONE} state_t;

    state_t               state;
    logic [1:0]           op_q;
    logic [PORT_BITS-1:0] port_q;
    logic [N-1:0]         data_q;
    logic                 drive;
    logic [3:0]           wait_cnt;
    logic [NUM_PORTS-1:0] sel_oh;
    logic                 bad_cmd;

`ifdef PIO_SHADOW_EN
    logic [N-1:0] out_sh [NUM_PORTS];
    logic [N-1:0] dir_sh [NUM_PORTS];
    assign bad_cmd = 32'(port_sel) >= NUM_PORTS;
`else
    assign bad_cmd = op == OP_SHADOW || 32'(port_sel) >= NUM_PORTS;
`endif

    assign sel_oh   = NUM_PORTS'(1) << port_q;
    assign data_bus = drive ? data_q : 'z;

    // Command FSM; every output is a register loaded on entry to the state that shows it
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            ack      <= 1'b0;
            err      <= 1'b0;
            rd_data  <= '0;
            read_in  <= '0;
            load_out <= '0;
            load_dir <= '0;
            drive    <= 1'b0;
            op_q     <= '0;
            port_q   <= '0;
            data_q   <= '0;
            wait_cnt <= '0;
`ifdef PIO_SHADOW_EN
            for (int i = 0; i < NUM_PORTS; i++) begin
                out_sh[i] <= '0;
                dir_sh[i] <= '0;
            end
`endif
        end else begin
            case (state)
                IDLE: if (req) begin
                    op_q   <= op;
                    port_q <= port_sel;
                    data_q <= wr_data;
                    busy   <= 1'b1;
                    if (bad_cmd) begin
                        state <= DONE;
                        ack   <= 1'b1;
                        err   <= 1'b1;
                    end
`ifdef PIO_SHADOW_EN
                    else if (op == OP_SHADOW) begin
                        state   <= DONE;
                        ack     <= 1'b1;
                        rd_data <= wr_data[0] ? dir_sh[port_sel] : out_sh[port_sel];
                    end
`endif
                    else begin
                        state <= SETUP;
                        drive <= op != OP_READ;
                    end
                end
                SETUP: begin
                    state    <= STROBE;
                    read_in  <= op_q == OP_READ ? sel_oh : '0;
                    load_out <= op_q == OP_OUT ? sel_oh : '0;
                    load_dir <= op_q == OP_DIR ? sel_oh : '0;
                end
                STROBE: begin
                    load_out <= '0;
                    load_dir <= '0;
                    wait_cnt <= 4'(READ_LAT - 1);
                    state    <= op_q == OP_READ ? WAIT : HOLD;
                end
                WAIT: if (wait_cnt == 4'd0) begin
                    state   <= DONE;
                    read_in <= '0;
                    rd_data <= data_bus;
                    ack     <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt - 4'd1;
                end
                HOLD: begin
                    state <= DONE;
                    drive <= 1'b0;
                    ack   <= 1'b1;
`ifdef PIO_SHADOW_EN
                    if (op_q == OP_OUT) out_sh[port_q] <= data_q;
                    else dir_sh[port_q] <= data_q;
`endif
                end
                DONE: begin
                    state <= IDLE;
                    ack   <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pio_bus_sequencer.sv
// tb_pio_bus_sequencer: cycle-timeline model of the sequencer plus directed literal checks.
`timescale 1ns/1ps
module tb_pio_bus_sequencer;
    localparam int N = 4, NP = 2, PB = 1, RL = 1, MAXC = 300;

    logic          clock = 0, reset = 1, req = 0;
    logic [1:0]    op = '0;
    logic [PB-1:0] port_sel = '0;
    logic [N-1:0]  wr_data = '0;
    logic          busy, ack, err;
    logic [N-1:0]  rd_data;
    logic [NP-1:0] read_in, load_out, load_dir;
    wire  [N-1:0]  data_bus;
    logic [N-1:0]  pv [NP];
    logic [N-1:0]  zz = 'z;
    int checks = 0, errors = 0, cyc = 0, free_at = 0, e;

    // expected outputs per cycle (cycle n = interval after the n-th rising edge)
    logic          e_busy [MAXC], e_ack [MAXC], e_err [MAXC];
    logic [NP-1:0] e_ri [MAXC], e_lo [MAXC], e_ld [MAXC];
    logic [N-1:0]  e_bus [MAXC], e_rd [MAXC];
`ifdef PIO_SHADOW_EN
    logic [N-1:0]  m_out [NP], m_dir [NP];
`endif

    pio_bus_sequencer #(.N(N), .NUM_PORTS(NP), .PORT_BITS(PB), .READ_LAT(RL)) dut (
        .clock(clock), .reset(reset), .req(req), .op(op), .port_sel(port_sel), .wr_data(wr_data),
        .busy(busy), .ack(ack), .err(err), .rd_data(rd_data), .data_bus(data_bus),
        .read_in(read_in), .load_out(load_out), .load_dir(load_dir)
    );

    // peripheral: the selected port drives its pin value while its READ_IN is high
    assign data_bus = read_in[0] ? pv[0] : read_in[1] ? pv[1] : 'z;

    always #5 clock = ~clock;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endfunction

    function automatic void clear_from(input int t0);
        for (int t = t0; t < MAXC; t++) begin
            e_busy[t] = 0; e_ack[t] = 0; e_err[t] = 0;
            e_ri[t] = '0; e_lo[t] = '0; e_ld[t] = '0;
            e_bus[t] = 'z; e_rd[t] = '0;
        end
    endfunction

    // command accepted at edge s occupies cycles s..s+len-1, ack on the last one
    function automatic void predict(input int s, input logic [1:0] o, input logic [PB-1:0] p, input logic [N-1:0] d);
        logic [NP-1:0] oh;
        bit bad;
        int len;
        oh  = NP'(1) << p;
        bad = int'(p) >= NP;
`ifndef PIO_SHADOW_EN
        bad = bad || o == 2'b11;
`endif
        len = (bad || o == 2'b11) ? 1 : (o == 2'b00) ? 3 + RL : 4;
        for (int t = s; t < s + len && t < MAXC; t++) e_busy[t] = 1;
        if (s + len - 1 < MAXC) begin
            e_ack[s + len - 1] = 1;
            e_err[s + len - 1] = bad;
        end
        if (!bad && o == 2'b00) begin
            for (int t = s + 1; t <= s + 1 + RL && t < MAXC; t++) begin
                e_ri[t] = oh;
                e_bus[t] = pv[p];
            end
            for (int t = s + len - 1; t < MAXC; t++) e_rd[t] = pv[p];
        end else if (!bad && o != 2'b11) begin
            for (int t = s; t <= s + 2 && t < MAXC; t++) e_bus[t] = d;
            if (s + 1 < MAXC) begin
                if (o == 2'b01) e_lo[s + 1] = oh;
                else e_ld[s + 1] = oh;
            end
`ifdef PIO_SHADOW_EN
            if (o == 2'b01) m_out[p] = d;
            else m_dir[p] = d;
`endif
        end
`ifdef PIO_SHADOW_EN
        if (!bad && o == 2'b11)
            for (int t = s; t < MAXC; t++) e_rd[t] = d[0] ? m_dir[p] : m_out[p];
`endif
        free_at = s + len + 1;
    endfunction

    // model: count edges, accept req only when the previous command has fully retired
    always @(posedge clock) begin
        cyc++;
        if (reset) begin
            clear_from(cyc < MAXC ? cyc : MAXC);
            free_at = 0;
`ifdef PIO_SHADOW_EN
            for (int i = 0; i < NP; i++) begin m_out[i] = '0; m_dir[i] = '0; end
`endif
        end else if (req && cyc >= free_at) begin
            predict(cyc, op, port_sel, wr_data);
        end
    end

    // compare every cycle on the falling edge
    always @(negedge clock) begin
        if (!reset && cyc < MAXC) begin
            chk("busy", 32'(busy), 32'(e_busy[cyc]));
            chk("ack", 32'(ack), 32'(e_ack[cyc]));
            if (e_ack[cyc]) chk("err", 32'(err), 32'(e_err[cyc]));
            chk("read_in", 32'(read_in), 32'(e_ri[cyc]));
            chk("load_out", 32'(load_out), 32'(e_lo[cyc]));
            chk("load_dir", 32'(load_dir), 32'(e_ld[cyc]));
            chk("data_bus", 32'(data_bus), 32'(e_bus[cyc]));
            chk("rd_data", 32'(rd_data), 32'(e_rd[cyc]));
        end
    end

    task automatic issue(input logic [1:0] o, input logic [PB-1:0] p, input logic [N-1:0] d, output int s);
        @(negedge clock);
        req = 1; op = o; port_sel = p; wr_data = d;
        @(posedge clock);
        #1 s = cyc;
        @(negedge clock);
        req = 0;
    endtask

    task automatic to_cycle(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clear_from(0);
        pv[0] = 4'b1010;
        pv[1] = 4'h5;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_read_in", 32'(read_in), 0);
        chk("rst_load_out", 32'(load_out), 0);
        chk("rst_load_dir", 32'(load_dir), 0);
        chk("rst_bus", 32'(data_bus), 32'(zz));
        chk("rst_rd", 32'(rd_data), 0);

        issue(2'b01, 1'b1, 4'hA, e);
        chk("wo_setup_bus", 32'(data_bus), 32'hA);
        chk("wo_setup_lo", 32'(load_out), 0);
        to_cycle(e + 1);
        chk("wo_strobe_lo", 32'(load_out), 32'b10);
        chk("wo_strobe_bus", 32'(data_bus), 32'hA);
        to_cycle(e + 2);
        chk("wo_hold_lo", 32'(load_out), 0);
        chk("wo_hold_bus", 32'(data_bus), 32'hA);
        to_cycle(e + 3);
        chk("wo_ack", 32'(ack), 1);
        chk("wo_err", 32'(err), 0);
        chk("wo_done_bus", 32'(data_bus), 32'(zz));

        issue(2'b00, 1'b0, 4'h0, e);
        chk("rd_setup_bus", 32'(data_bus), 32'(zz));
        to_cycle(e + 1);
        chk("rd_strobe_ri", 32'(read_in), 32'b01);
        to_cycle(e + 2);
        chk("rd_wait_ri", 32'(read_in), 32'b01);
        to_cycle(e + 3);
        chk("rd_ack", 32'(ack), 1);
        chk("rd_data_a", 32'(rd_data), 32'hA);
        chk("rd_done_ri", 32'(read_in), 0);

`ifdef PIO_SHADOW_EN
        issue(2'b10, 1'b0, 4'h3, e);
        to_cycle(e + 4);
        issue(2'b11, 1'b0, 4'h1, e);
        chk("sh_ack", 32'(ack), 1);
        chk("sh_err", 32'(err), 0);
        chk("sh_rd", 32'(rd_data), 32'h3);
        chk("sh_strobes", 32'({read_in, load_out, load_dir}), 0);
`else
        issue(2'b11, 1'b0, 4'hF, e);
        chk("rej_ack", 32'(ack), 1);
        chk("rej_err", 32'(err), 1);
        chk("rej_rd_kept", 32'(rd_data), 32'hA);
        to_cycle(e + 1);
        chk("rej_idle", 32'(busy), 0);
`endif

        issue(2'b00, 1'b1, 4'h0, e);
        repeat (6) @(negedge clock);
        issue(2'b10, 1'b0, 4'h3, e);
        repeat (6) @(negedge clock);
        pv[1] = 4'hC;

        issue(2'b01, 1'b0, 4'h6, e);
        req = 1; op = 2'b10; port_sel = 1'b1; wr_data = 4'hF;
        to_cycle(e + 1);
        req = 0;
        to_cycle(e + 2);
        req = 1; op = 2'b00; port_sel = 1'b1; wr_data = 4'h0;
        to_cycle(e + 3);
        chk("b2b_ack1", 32'(ack), 1);
        to_cycle(e + 4);
        chk("b2b_idle", 32'(busy), 0);
        to_cycle(e + 5);
        chk("b2b_start", 32'(busy), 1);
        req = 0;
        to_cycle(e + 8);
        chk("b2b_ack2", 32'(ack), 1);
        chk("b2b_rd", 32'(rd_data), 32'hC);

        issue(2'b01, 1'b1, 4'h5, e);
        to_cycle(e + 1);
        #1 reset = 1;
        #1;
        chk("mid_rst_lo", 32'(load_out), 0);
        chk("mid_rst_bus", 32'(data_bus), 32'(zz));
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_rd", 32'(rd_data), 0);
        @(posedge clock);
        @(negedge clock);
        reset = 0;

        issue(2'b10, 1'b1, 4'h9, e);
        to_cycle(e + 5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
